// File: rtl/dram_tx_streamer_pkg.sv
// dram_tx_streamer_pkg: FSM encoding and frame-map constants shared by both ends of the DRAM frame path.
package dram_tx_streamer_pkg;
  typedef enum logic [2:0] {IDLE, RD_WAIT, LOAD, TX_WAIT, DONE} state_t;
  localparam int FRAME_BYTES = 16384;
  localparam int FRAME_START = 0;
endpackage

// File: rtl/dram_tx_streamer.sv
// dram_tx_streamer: reads a finished frame out of DRAM byte by byte and hands each byte to the UART transmitter.
module dram_tx_streamer
  import dram_tx_streamer_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = FRAME_START,
  parameter int IMG_BYTES  = FRAME_BYTES,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] dm_data,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              tx_finish
);
  localparam int CNT_W  = $clog2(IMG_BYTES) + 1;
  localparam int WAIT_W = $clog2(RD_LAT + 1);

  if (IMG_BYTES < 1 || RD_LAT < 1) begin : g_bad_param
    $error("IMG_BYTES and RD_LAT must both be at least 1");
  end
  if (longint'(START_ADDR) + longint'(IMG_BYTES) > (longint'(1) << ADDR_W)) begin : g_bad_map
    $error("frame extends past the top of the DRAM address space");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      addr_q  <= ADDR_W'(START_ADDR);
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    fin_d   = fin_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RD_WAIT;
          addr_d  = ADDR_W'(START_ADDR);
          cnt_d   = '0;
          wait_d  = WAIT_W'(RD_LAT);
          busy_d  = 1'b1;
          fin_d   = 1'b0;
        end
      end
      RD_WAIT: begin
        wait_d  = wait_q - 1'b1;
        state_d = (wait_q == WAIT_W'(1)) ? LOAD : RD_WAIT;
      end
      LOAD: begin
        data_d  = dm_data;
        start_d = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // a tx_done landing in the tx_start cycle belongs to the previous byte
        if (tx_done && !start_q) begin
          if (cnt_q == CNT_W'(IMG_BYTES - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            wait_d  = WAIT_W'(RD_LAT);
            state_d = RD_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dm_addr   = addr_q;
  assign tx_data   = data_q;
  assign tx_start  = start_q;
  assign busy      = busy_q;
  assign tx_finish = fin_q;
endmodule

// File: tb/tb_dram_tx_streamer.sv
// tb_dram_tx_streamer: directed and randomized frame streaming against a DRAM and UART TX model.
module tb_dram_tx_streamer;
  localparam int AW      = 18;
  localparam int B_START = (1 << AW) - 2;

  logic clk = 0, rst = 0, start_a = 0, start_b = 0, stray = 0;
  logic done_a = 0, done_b = 0, tx_done_a;
  logic [7:0] dm_data_a = 0, dm_data_b = 0, tx_data_a, tx_data_b;
  logic [AW-1:0] dm_addr_a, dm_addr_b;
  logic tx_start_a, tx_start_b, busy_a, busy_b, fin_a, fin_b;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] got_a[$], got_b[$], exp_q[$];
  logic [AW-1:0] adr_b[$];
  int n_assert = 0, n_fail = 0, tx_dly = 10, ua_a = 0, ua_b = 0;
  bit ok;

  always #5 clk = ~clk;
  assign tx_done_a = done_a | stray;

  dram_tx_streamer #(.ADDR_W(AW), .DATA_W(8), .START_ADDR(0), .IMG_BYTES(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .tx_done(tx_done_a), .dm_data(dm_data_a),
    .dm_addr(dm_addr_a), .tx_data(tx_data_a), .tx_start(tx_start_a), .busy(busy_a), .tx_finish(fin_a));

  dram_tx_streamer #(.ADDR_W(AW), .DATA_W(8), .START_ADDR(B_START), .IMG_BYTES(2), .RD_LAT(1)) u_top (
    .clk(clk), .rst(rst), .start(start_b), .tx_done(done_b), .dm_data(dm_data_b),
    .dm_addr(dm_addr_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .busy(busy_b), .tx_finish(fin_b));

  // DRAM with one-cycle read latency, UART TX answering tx_start after tx_dly clocks, byte monitors
  always @(posedge clk) begin
    dm_data_a <= mem[dm_addr_a];
    dm_data_b <= mem[dm_addr_b];
    done_a <= 1'b0;
    done_b <= 1'b0;
    if (tx_start_a) ua_a <= tx_dly;
    else if (ua_a > 0) begin
      ua_a <= ua_a - 1;
      if (ua_a == 1) done_a <= 1'b1;
    end
    if (tx_start_b) ua_b <= tx_dly;
    else if (ua_b > 0) begin
      ua_b <= ua_b - 1;
      if (ua_b == 1) done_b <= 1'b1;
    end
    if (rst && tx_start_a) got_a.push_back(tx_data_a);
    if (rst && tx_start_b) begin
      got_b.push_back(tx_data_b);
      adr_b.push_back(dm_addr_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int which, output bit hit);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (which == 0) ? tx_done_a : (which == 1) ? tx_start_a : (which == 2) ? fin_a : fin_b;
    end
  endtask

  task automatic load_frame(input int base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      mem[base + i] = 8'($urandom);
      exp_q.push_back(mem[base + i]);
    end
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, got_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_a.size()) ? 32'(got_a[i]) : 32'hDEAD, exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_q = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) mem[i] = exp_q[i];
    repeat (2) @(negedge clk);
    check("rst_addr", dm_addr_a, 0);
    check("rst_data", tx_data_a, 0);
    check("rst_start", tx_start_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fin", fin_a, 0);
    check("rst_addr_b", dm_addr_b, B_START);
    rst = 1;
    // fixed frame: latency from start and from each tx_done
    @(negedge clk); start_a = 1;
    @(posedge clk); #1; start_a = 0;
    check("t2_addr0", dm_addr_a, 0);
    check("t2_busy", busy_a, 1);
    check("t2_early1", tx_start_a, 0);
    @(posedge clk); #1; check("t2_early2", tx_start_a, 0);
    @(posedge clk); #1;
    check("t2_first", tx_start_a, 1);
    check("t1_byte0", tx_data_a, 8'hA5);
    @(posedge clk); #1; check("t2_pulse", tx_start_a, 0);
    for (int b = 1; b < 4; b++) begin
      wait_sig(0, ok); check("t2_done_to", ok, 1);
      check("t1_hold", tx_data_a, exp_q[b-1]);
      @(posedge clk); #1;
      @(posedge clk); #1; check("t2_gap", tx_start_a, 0);
      @(posedge clk); #1;
      check("t2_next", tx_start_a, 1);
      check("t2_addr", dm_addr_a, b);
      check("t1_byte", tx_data_a, exp_q[b]);
    end
    wait_sig(0, ok); check("t1_last_to", ok, 1);
    check("t1_fin_pre", fin_a, 0);
    @(posedge clk); #1;
    check("t1_fin", fin_a, 1);
    check("t1_busy", busy_a, 0);
    cmp_frame("t1_frame");
    // random frame restarted from DONE, with stray start/tx_done pulses
    got_a.delete();
    load_frame(0, 4);
    tx_dly = $urandom_range(6, 12);
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    check("t3_fin_clr", fin_a, 0);
    check("t3_busy", busy_a, 1);
    wait_sig(1, ok); check("t3_s0_to", ok, 1);
    wait_sig(1, ok); check("t3_s1_to", ok, 1);
    stray = 1; start_a = 1;
    @(posedge clk); #1; stray = 0; start_a = 0;
    repeat (2) begin
      @(negedge clk); start_a = 1;
      @(negedge clk); start_a = 0;
    end
    @(posedge clk); #1;
    check("t3_ign_addr", dm_addr_a, 1);
    check("t3_ign_start", tx_start_a, 0);
    check("t3_ign_busy", busy_a, 1);
    wait_sig(0, ok); check("t3_done_to", ok, 1);
    @(posedge clk); #1; stray = 1;
    @(posedge clk); #1; stray = 0;
    wait_sig(2, ok); check("t3_fin_to", ok, 1);
    check("t3_busy_end", busy_a, 0);
    cmp_frame("t3_frame");
    // reset in TX_WAIT of the third byte, then a clean restart
    got_a.delete();
    load_frame(0, 4);
    mem[2] = 8'($urandom_range(1, 255));
    exp_q[2] = mem[2];
    tx_dly = 10;
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    for (int i = 0; i < 3; i++) begin
      wait_sig(1, ok); check("t4_s_to", ok, 1);
    end
    check("t4_pre_data", tx_data_a, exp_q[2]);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    check("t4_addr", dm_addr_a, 0);
    check("t4_data", tx_data_a, 0);
    check("t4_start", tx_start_a, 0);
    check("t4_busy", busy_a, 0);
    check("t4_fin", fin_a, 0);
    @(negedge clk); rst = 1;
    repeat (15) @(negedge clk);
    check("t4_idle_busy", busy_a, 0);
    check("t4_idle_start", tx_start_a, 0);
    got_a.delete();
    load_frame(0, 4);
    @(negedge clk); start_a = 1;
    @(posedge clk); #1; start_a = 0;
    check("t4_restart_addr", dm_addr_a, 0);
    wait_sig(2, ok); check("t4_fin_to", ok, 1);
    cmp_frame("t4_frame");
    // frame ending exactly at the top of the address space
    load_frame(B_START, 2);
    tx_dly = $urandom_range(3, 12);
    @(negedge clk); start_b = 1;
    @(negedge clk); start_b = 0;
    check("t5_addr0", dm_addr_b, B_START);
    wait_sig(3, ok); check("t5_fin_to", ok, 1);
    check("t5_len", got_b.size(), 2);
    for (int i = 0; i < 2; i++) begin
      check("t5_addr", (i < adr_b.size()) ? 32'(adr_b[i]) : 32'hDEAD, B_START + i);
      check("t5_byte", (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD, exp_q[i]);
    end
    check("t5_busy", busy_b, 0);
    check("t5_addr_end", dm_addr_b, B_START + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
